sc_ir_sequencer: RTL
====================

# sc_ir_sequencer

Multi-cycle fetch/decode/execute controller for the uDataPath instruction register and its surrounding datapath. It requests instruction words from memory and strobes the instruction register write. It reads back the decoded fields (OP, OP2, OP3, BIT13) and sequences the register-bank bus enables, ALU operation, memory strobes, PC update and register write-back for the supported ARC instruction subset. It sits between the memory interface and the datapath and is the only block that drives the instruction register write strobe.

## Interface
- MEM_TIMEOUT, 8'd32 — maximum wait cycles for memory ready; 0 disables the timeout.
- ALUOP_WIDTH, 4 — width of the ALU operation code.

- SC_IRSeq_CLOCK_50  in  1  system clock; the sequencer updates on posedge.
- SC_RegIR_Reset_InHigh  in  1  reset, asynchronous, active-high.
- SC_IRSeq_Run_InHigh  in  1  run enable, sampled in IDLE, WB and at store completion.
- SC_IRSeq_MemReady_InHigh  in  1  memory access complete.
- SC_IRSeq_OP / _OP2 / _OP3 / _BIT13  in  2/3/6/1  instruction register fields.
- SC_IRSeq_MemRead_Out, _MemWrite_Out  out  1  memory strobes.
- SC_IRSeq_IRWrite_Out  out  1  instruction register write enable.
- SC_IRSeq_PCWrite_Out  out  1  PC ← PC+4.
- SC_IRSeq_RegWrite_Out  out  1  register bank write of rd.
- SC_IRSeq_EnableBusA_Out, _EnableBusB_Out  out  1  register bank bus enables.
- SC_IRSeq_UseImm_Out  out  1  ALU B operand from simm13.
- SC_IRSeq_ALUOp_Out  out  ALUOP_WIDTH  ALU op: 0 NOP, 1 ADD, 2 AND, 3 OR, 4 ORN, 5 SRL, 6 SETHI.
- SC_IRSeq_State_Out  out  3  current state encoding.
- SC_IRSeq_FaultCode_Out  out  2  00 none, 01 illegal, 10 fetch timeout, 11 memory timeout.

## Operation
- States (encoding): IDLE 0, FETCH 1, LOADIR 2, DECODE 3, EXEC 4, MEMACC 5, WB 6, FAULT 7.
- **IDLE:**
  - All strobes are 0.
  - Run=1 → FETCH.
- **FETCH:**
  - MemRead=1.
  - Ready → LOADIR.
  - Timeout → FAULT, code 10.
- **LOADIR:**
  - IRWrite=1 for exactly one cycle; the instruction register captures on the mid-cycle negedge.
  - Always → DECODE.
- **DECODE:**
  - PCWrite=1 for one cycle.
  - Instruction classification:
    - OP=00 with OP2=100 is SETHI → WB.
    - OP=10 with OP3 ∈ {010000 addcc, 010001 andcc, 010010 orcc, 010110 orncc, 100110 srl} is arithmetic → EXEC.
    - OP=11 with OP3 ∈ {000000 ld, 000100 st} is memory → EXEC.
    - Anything else, including Bicc, call and jmpl in this revision → FAULT, code 01. PCWrite is suppressed for illegal instructions.
- **EXEC:**
  - EnableBusA=1, EnableBusB=!BIT13, UseImm=BIT13.
  - ALUOp comes from OP3 for arithmetic and is ADD for memory address computation.
  - Arithmetic → WB; memory → MEMACC.
- **MEMACC:**
  - ld asserts MemRead; st asserts MemWrite.
  - ALUOp stays ADD and the bus enables are held.
  - Ready: ld → WB; st → FETCH if Run=1, else IDLE.
  - Timeout → FAULT, code 11.
- **WB:**
  - RegWrite=1 for one cycle.
  - ALUOp is SETHI for sethi and holds the EXEC value otherwise.
  - → FETCH if Run=1, else IDLE.
- **FAULT:**
  - All strobes are 0 and FaultCode is held.
  - The only exit is reset.
- **Wait counter:** 8-bit, cleared on entry to FETCH and MEMACC, incremented each cycle without ready.
  - Timeout fires when count == MEM_TIMEOUT-1 and ready is low.
  - Ready in the limit cycle wins over timeout.
- **Run deasserted mid-instruction:** the current instruction completes, then the sequencer goes to IDLE.

## Timing
- Reset value of every output is 0, including state IDLE and FaultCode 00. Reset takes effect immediately and aborts any access in progress.
- Outputs are Moore: decoded from the state register plus the IR fields only. There is no combinational path from MemReady or Run to any output.
- Latency from FETCH entry, with ready in the first cycle of each access:
  - sethi: 4 cycles.
  - arithmetic: 5 cycles.
  - st: 5 cycles.
  - ld: 6 cycles.
- Each memory wait cycle adds one cycle of latency.
- IR fields are stable from the LOADIR negedge onward; DECODE samples them at the next posedge.
- Back-to-back instructions have no idle gap while Run=1.

## Structure
- Package sc_irseq_pkg holds:
  - state encodings;
  - ALUOp codes;
  - OP, OP2 and OP3 constants;
  - fault codes.
- Sub-module sc_irseq_decode: combinational classifier taking OP/OP2/OP3 and producing class (sethi/arith/ld/st), ALUOp and legal. It is used in DECODE and EXEC.
- Top level contains the state register, the wait counter and the output decode.

## Test plan
- addcc (OP=10, OP3=010000, BIT13=0), ready immediate → states 1,2,3,4,6; IRWrite in cycle 2, PCWrite in cycle 3, EnableBusA=EnableBusB=1 and ALUOp=1 in cycle 4, RegWrite in cycle 5.
- ld with ready delayed 3 cycles in MEMACC → MemRead held 4 cycles, then WB with RegWrite=1; total 9 cycles.
- st with ready never asserted, MEM_TIMEOUT=32 → FAULT after 32 MEMACC cycles, FaultCode=11, MemWrite drops to 0.
- OP=01 (call) → FAULT in the cycle after DECODE, FaultCode=01, PCWrite never asserted.
- Reset pulsed during MEMACC of a ld → next cycle IDLE, all outputs 0; with Run=1 after reset, a new FETCH begins.
- Run dropped during EXEC of orcc → WB completes, then IDLE. Ready asserted exactly in the 32nd FETCH wait cycle → LOADIR, not FAULT.

Source files
------------

// File: rtl/sc_irseq_pkg.sv
// Shared encodings for the uDataPath IR sequencer:
// FSM states, ALU op codes, ARC opcode fields and fault codes.
package sc_irseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOADIR = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEMACC = 3'd5,
    S_WB     = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    C_SETHI = 2'd0,
    C_ARITH = 2'd1,
    C_LD    = 2'd2,
    C_ST    = 2'd3
  } iclass_t;

  localparam int ALU_NOP   = 0;
  localparam int ALU_ADD   = 1;
  localparam int ALU_AND   = 2;
  localparam int ALU_OR    = 3;
  localparam int ALU_ORN   = 4;
  localparam int ALU_SRL   = 5;
  localparam int ALU_SETHI = 6;

  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  localparam logic [2:0] OP2_SETHI = 3'b100;

  localparam logic [5:0] OP3_ADDCC = 6'b010000;
  localparam logic [5:0] OP3_ANDCC = 6'b010001;
  localparam logic [5:0] OP3_ORCC  = 6'b010010;
  localparam logic [5:0] OP3_ORNCC = 6'b010110;
  localparam logic [5:0] OP3_SRL   = 6'b100110;
  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_ST    = 6'b000100;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_ILL   = 2'b01;
  localparam logic [1:0] FC_FETCH = 2'b10;
  localparam logic [1:0] FC_MEM   = 2'b11;

endpackage

// File: rtl/sc_irseq_decode.sv
// Combinational instruction classifier for the IR sequencer:
// maps OP/OP2/OP3 onto class, ALU op and legality.
module sc_irseq_decode
  import sc_irseq_pkg::*;
#(
  parameter int ALUOP_WIDTH = 4
) (
  input  logic [1:0]             i_op,
  input  logic [2:0]             i_op2,
  input  logic [5:0]             i_op3,
  output iclass_t                o_class,
  output logic [ALUOP_WIDTH-1:0] o_aluop,
  output logic                   o_legal
);

  logic w_sethi;
  logic w_alu;
  logic w_mem;

  assign w_sethi = (i_op == OP_FMT2) && (i_op2 == OP2_SETHI);
  assign w_alu   = (i_op == OP_ALU);
  assign w_mem   = (i_op == OP_MEM);

  always_comb begin
    o_class = C_ARITH;
    o_aluop = ALUOP_WIDTH'(ALU_NOP);
    o_legal = 1'b0;
    unique case (1'b1)
      w_sethi: begin
        o_class = C_SETHI;
        o_aluop = ALUOP_WIDTH'(ALU_SETHI);
        o_legal = 1'b1;
      end
      w_alu: begin
        o_class = C_ARITH;
        o_legal = 1'b1;
        case (i_op3)
          OP3_ADDCC: o_aluop = ALUOP_WIDTH'(ALU_ADD);
          OP3_ANDCC: o_aluop = ALUOP_WIDTH'(ALU_AND);
          OP3_ORCC:  o_aluop = ALUOP_WIDTH'(ALU_OR);
          OP3_ORNCC: o_aluop = ALUOP_WIDTH'(ALU_ORN);
          OP3_SRL:   o_aluop = ALUOP_WIDTH'(ALU_SRL);
          default:   o_legal = 1'b0;
        endcase
      end
      w_mem: begin
        o_aluop = ALUOP_WIDTH'(ALU_ADD);
        o_legal = 1'b1;
        case (i_op3)
          OP3_LD:  o_class = C_LD;
          OP3_ST:  o_class = C_ST;
          default: o_legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sc_ir_sequencer.sv
// Fetch/decode/execute controller for the uDataPath instruction
// register: Moore FSM, memory wait counter and output decode.
module sc_ir_sequencer
  import sc_irseq_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd32,
  parameter int         ALUOP_WIDTH = 4
) (
  input  logic                   SC_IRSeq_CLOCK_50,
  input  logic                   SC_RegIR_Reset_InHigh,
  input  logic                   SC_IRSeq_Run_InHigh,
  input  logic                   SC_IRSeq_MemReady_InHigh,
  input  logic [1:0]             SC_IRSeq_OP,
  input  logic [2:0]             SC_IRSeq_OP2,
  input  logic [5:0]             SC_IRSeq_OP3,
  input  logic                   SC_IRSeq_BIT13,
  output logic                   SC_IRSeq_MemRead_Out,
  output logic                   SC_IRSeq_MemWrite_Out,
  output logic                   SC_IRSeq_IRWrite_Out,
  output logic                   SC_IRSeq_PCWrite_Out,
  output logic                   SC_IRSeq_RegWrite_Out,
  output logic                   SC_IRSeq_EnableBusA_Out,
  output logic                   SC_IRSeq_EnableBusB_Out,
  output logic                   SC_IRSeq_UseImm_Out,
  output logic [ALUOP_WIDTH-1:0] SC_IRSeq_ALUOp_Out,
  output logic [2:0]             SC_IRSeq_State_Out,
  output logic [1:0]             SC_IRSeq_FaultCode_Out
);

  state_t                   r_state;
  state_t                   w_next;
  logic [7:0]               r_wait;
  logic [1:0]               r_fault;
  logic [1:0]               w_fault_nxt;
  iclass_t                  w_class;
  logic [ALUOP_WIDTH-1:0]   w_aluop;
  logic                     w_legal;
  logic                     w_waiting;
  logic                     w_timeout;
  logic                     w_ready;
  logic                     w_run;

  assign w_ready = SC_IRSeq_MemReady_InHigh;
  assign w_run   = SC_IRSeq_Run_InHigh;

  sc_irseq_decode #(
    .ALUOP_WIDTH(ALUOP_WIDTH)
  ) u_decode (
    .i_op    (SC_IRSeq_OP),
    .i_op2   (SC_IRSeq_OP2),
    .i_op3   (SC_IRSeq_OP3),
    .o_class (w_class),
    .o_aluop (w_aluop),
    .o_legal (w_legal)
  );

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMACC);
  // Ready in the limit cycle is handled first, so it beats the timeout.
  assign w_timeout = (MEM_TIMEOUT != 8'd0) && !w_ready
                   && (r_wait == MEM_TIMEOUT - 8'd1);

  always_ff @(posedge SC_IRSeq_CLOCK_50 or posedge SC_RegIR_Reset_InHigh) begin
    if (SC_RegIR_Reset_InHigh) begin
      r_state <= S_IDLE;
      r_wait  <= 8'd0;
      r_fault <= FC_NONE;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault_nxt;
      if (w_waiting && (w_next == r_state))
        r_wait <= r_wait + 8'd1;
      else
        r_wait <= 8'd0;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_fault_nxt = r_fault;
    case (r_state)
      S_IDLE:   if (w_run) w_next = S_FETCH;
      S_FETCH: begin
        if (w_ready) begin
          w_next = S_LOADIR;
        end else if (w_timeout) begin
          w_next      = S_FAULT;
          w_fault_nxt = FC_FETCH;
        end
      end
      S_LOADIR: w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
          w_next      = S_FAULT;
          w_fault_nxt = FC_ILL;
        end else if (w_class == C_SETHI) begin
          w_next = S_WB;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((w_class == C_LD) || (w_class == C_ST))
          w_next = S_MEMACC;
        else
          w_next = S_WB;
      end
      S_MEMACC: begin
        if (w_ready) begin
          if (w_class == C_LD) w_next = S_WB;
          else w_next = w_run ? S_FETCH : S_IDLE;
        end else if (w_timeout) begin
          w_next      = S_FAULT;
          w_fault_nxt = FC_MEM;
        end
      end
      S_WB:     w_next = w_run ? S_FETCH : S_IDLE;
      default:  w_next = S_FAULT;
    endcase
  end

  always_comb begin
    SC_IRSeq_MemRead_Out    = 1'b0;
    SC_IRSeq_MemWrite_Out   = 1'b0;
    SC_IRSeq_IRWrite_Out    = 1'b0;
    SC_IRSeq_PCWrite_Out    = 1'b0;
    SC_IRSeq_RegWrite_Out   = 1'b0;
    SC_IRSeq_EnableBusA_Out = 1'b0;
    SC_IRSeq_EnableBusB_Out = 1'b0;
    SC_IRSeq_UseImm_Out     = 1'b0;
    SC_IRSeq_ALUOp_Out      = ALUOP_WIDTH'(ALU_NOP);
    case (r_state)
      S_FETCH:  SC_IRSeq_MemRead_Out = 1'b1;
      S_LOADIR: SC_IRSeq_IRWrite_Out = 1'b1;
      S_DECODE: SC_IRSeq_PCWrite_Out = w_legal;
      S_EXEC: begin
        SC_IRSeq_EnableBusA_Out = 1'b1;
        SC_IRSeq_EnableBusB_Out = !SC_IRSeq_BIT13;
        SC_IRSeq_UseImm_Out     = SC_IRSeq_BIT13;
        SC_IRSeq_ALUOp_Out      = w_aluop;
      end
      S_MEMACC: begin
        SC_IRSeq_MemRead_Out    = (w_class == C_LD);
        SC_IRSeq_MemWrite_Out   = (w_class == C_ST);
        SC_IRSeq_EnableBusA_Out = 1'b1;
        SC_IRSeq_EnableBusB_Out = !SC_IRSeq_BIT13;
        SC_IRSeq_UseImm_Out     = SC_IRSeq_BIT13;
        SC_IRSeq_ALUOp_Out      = ALUOP_WIDTH'(ALU_ADD);
      end
      S_WB: begin
        SC_IRSeq_RegWrite_Out = 1'b1;
        SC_IRSeq_ALUOp_Out    = w_aluop;
      end
      default: ;
    endcase
  end

  assign SC_IRSeq_State_Out     = r_state;
  assign SC_IRSeq_FaultCode_Out = r_fault;

endmodule
